// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control FSM: state codes,
// instruction field codes and datapath mux select values.
package mc_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_PASSB = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_REG = 2'b00;
  localparam logic [1:0] IMM_8   = 2'b01;
  localparam logic [1:0] IMM_12  = 2'b10;
  localparam logic [1:0] IMM_24  = 2'b11;

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_MOV) || (cmd == CMD_CMP);
  endfunction

  function automatic logic [1:0] alu_ctl_for(input logic [3:0] cmd);
    logic [1:0] ctl;
    case (cmd)
      CMD_SUB, CMD_CMP: ctl = ALU_SUB;
      CMD_MOV:          ctl = ALU_PASSB;
      default:          ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_cond_unit.sv
// Architectural Z flag register and condition-pass evaluation for EQ/NE/AL.
module cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_write,
  input  logic       alu_zero,
  input  logic [3:0] cond,
  output logic       cond_ex
);

  logic z_d, z_q;

  always_comb begin
    z_d = z_q;
    if (flag_write) z_d = alu_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) z_q <= 1'b0;
    else        z_q <= z_d;
  end

  always_comb begin
    cond_ex = (cond == COND_AL) | ((cond == COND_EQ) & z_q) | ((cond == COND_NE) & ~z_q);
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for the multicycle ARM-subset datapath: sequences
// fetch/decode/execute/memory/writeback and drives every select and enable.
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [31:0]        Instr,
  input  logic               ALUZero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUControl,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic [1:0]         RegSrc,
  output logic               FlagWrite,
  output logic [STATE_W-1:0] State
);

  state_t state_q, state_d;

  logic       pc_write, mem_write, ir_write, reg_write, flag_write;
  logic       adr_src, alu_src_a;
  logic [1:0] result_src, alu_control, alu_src_b, imm_src, reg_src;
  logic       cond_ex;

  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       i_bit, u_bit, sl_bit;

  assign cond   = Instr[31:28];
  assign op     = Instr[27:26];
  assign i_bit  = Instr[25];
  assign cmd    = Instr[24:21];
  assign u_bit  = Instr[23];
  assign sl_bit = Instr[20];

  // Operand fields are consumed by the datapath, not by the sequencer.
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instr[19:0];

  cond_unit u_cond (
    .clk        (CLK),
    .rst_n      (nRESET),
    .flag_write (FlagWrite),
    .alu_zero   (ALUZero),
    .cond       (cond),
    .cond_ex    (cond_ex)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = RES_ALUOUT;
    alu_control = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RD2;
    imm_src     = IMM_REG;
    reg_write   = 1'b0;
    reg_src     = 2'b00;
    flag_write  = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        reg_src    = {(op == OP_MEM) & ~sl_bit, op == OP_BR};
        case (op)
          OP_DP:   imm_src = i_bit ? IMM_8 : IMM_REG;
          OP_MEM:  imm_src = IMM_12;
          OP_BR:   imm_src = IMM_24;
          default: imm_src = IMM_REG;
        endcase
        // Failed condition or unsupported encoding retires as a no-op here.
        if (cond_ex) begin
          case (op)
            OP_MEM:  state_d = S_MEMADR;
            OP_BR:   state_d = S_BRANCH;
            OP_DP:   if (cmd_supported(cmd)) state_d = i_bit ? S_EXECI : S_EXECR;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_12;
        alu_control = u_bit ? ALU_ADD : ALU_SUB;
        state_d     = sl_bit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        reg_src   = 2'b10;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b   = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RD2;
        imm_src     = (state_q == S_EXECI) ? IMM_8 : IMM_REG;
        alu_control = alu_ctl_for(cmd);
        flag_write  = (cmd == CMD_CMP) | sl_bit;
        state_d     = (cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BRANCH: begin
        pc_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_24;
        result_src = RES_ALU;
        reg_src    = 2'b01;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are held off for the whole time reset is asserted.
  assign PCWrite    = pc_write   & nRESET;
  assign IRWrite    = ir_write   & nRESET;
  assign MemWrite   = mem_write  & nRESET;
  assign RegWrite   = reg_write  & nRESET;
  assign FlagWrite  = flag_write & nRESET;
  assign AdrSrc     = adr_src;
  assign ResultSrc  = result_src;
  assign ALUControl = alu_control;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ImmSrc     = imm_src;
  assign RegSrc     = reg_src;
  assign State      = state_q;

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multicycle sequencer for the ARM-subset datapath: ADD, SUB, MOV, CMP, LDR, STR, B and BL, with conditions EQ, NE and AL.
- Steps one shared ALU and one unified instruction/data memory through fetch, decode, execute, memory and writeback states.
- Holds the architectural Z flag and drives every datapath mux select and write enable each cycle.
- Sits between the instruction register (IR) output and the multicycle datapath.

Parameters:
- STATE_W, 4, width of the state register (fixed encodings in the package).

Ports:
- CLK  input  1  system clock, rising-edge.
- nRESET  input  1  asynchronous active-low reset.
- Instr  input  32  IR contents; stable from the cycle after FETCH.
- ALUZero  input  1  zero output of the ALU in the current cycle.
- PCWrite  output  1  PC register load enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write enable.
- IRWrite  output  1  IR load enable.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU direct.
- ALUControl  output  2  ALU operation: 00 = add, 01 = sub, 10 = pass SrcB.
- ALUSrcA  output  1  SrcA select: 0 = RD1, 1 = PC.
- ALUSrcB  output  2  SrcB select: 00 = RD2, 01 = ExtImm, 10 = constant 4.
- ImmSrc  output  2  immediate extend: 00 = reg (don't care), 01 = imm8, 10 = imm12, 11 = imm24.
- RegWrite  output  1  register file write enable.
- RegSrc  output  2  register address select: [0] = PC as Rn for branch, [1] = Rd as Rm for STR.
- FlagWrite  output  1  Z flag update enable in the current cycle.
- State  output  4  current state, for debug.

Behaviour:
- Moore FSM.
  - Outputs are combinational from State and Instr fields.
  - Outputs not listed for a state are 0.
- State codes:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5.
  - EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9.
- Reset:
  - nRESET low takes State to FETCH and Zflag to 0 asynchronously.
  - While nRESET is low, PCWrite, IRWrite, MemWrite, RegWrite and FlagWrite are forced to 0.
  - All other outputs show their FETCH values while nRESET is low.
  - Reset mid-instruction aborts it; no partial write occurs after the assertion edge.
- FETCH:
  - Outputs: AdrSrc = 0, IRWrite = 1, ALUSrcA = 1, ALUSrcB = 10, ALUControl = 00, ResultSrc = 10, PCWrite = 1.
  - Next state is always DECODE.
- DECODE:
  - Outputs: ALUSrcA = 1, ALUSrcB = 10, ALUControl = 00, ResultSrc = 10.
  - RegSrc and ImmSrc are decoded from Instr.
  - CondEx = (Cond == 1110) | (Cond == 0000 & Zflag) | (Cond == 0001 & ~Zflag); Zflag is the registered flag.
  - CondEx = 0 → FETCH.
  - Op = 01 → MEMADR.
  - Op = 10 → BRANCH.
  - Op = 00 with I = Instr[25] = 0 → EXECR; with I = 1 → EXECI.
  - Cmd = Instr[24:21] not in {0100, 0010, 1101, 1010}, or Op = 11 → FETCH (no-op).
- MEMADR:
  - Outputs: ALUSrcA = 0, ALUSrcB = 01, ImmSrc = 10.
  - ALUControl = 00 if U = Instr[23] = 1, else 01.
  - Next state: L = Instr[20] = 1 → MEMRD; L = 0 → MEMWR.
- MEMRD: AdrSrc = 1; next state MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1; next state FETCH.
- MEMWR: AdrSrc = 1, MemWrite = 1, RegSrc[1] = 1; next state FETCH.
- EXECR / EXECI:
  - ALUSrcA = 0.
  - ALUSrcB = 00 in EXECR; ALUSrcB = 01 with ImmSrc = 01 in EXECI.
  - ALUControl: ADD = 00, SUB = 01, MOV = 10, CMP = 01.
  - FlagWrite = 1 when Cmd = CMP or S = Instr[20] = 1; Zflag loads ALUZero on that rising edge.
  - Next state: CMP → FETCH; all others → ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1; next state FETCH.
- BRANCH:
  - Outputs: ALUSrcA = 1, ALUSrcB = 01, ImmSrc = 11, ALUControl = 00, ResultSrc = 10, PCWrite = 1, RegSrc[0] = 1.
  - BL performs no link write (RegWrite = 0).
  - Next state FETCH.
- Latency in cycles, including FETCH:
  - LDR 5; STR 4; ADD/SUB/MOV 4; CMP 3; B/BL 3.
  - Condition-failed or unsupported instruction: 2.
- Any unused state code → FETCH on the next edge, with all enables 0 in that cycle.
- Simultaneous FlagWrite and a DECODE check cannot occur: they are in distinct states, so flags written by instruction N are visible to instruction N+1.

Decomposition:
- Package mc_ctrl_pkg:
  - state localparams;
  - Cond codes EQ/NE/AL;
  - Op codes 00/01/10;
  - Cmd codes ADD/SUB/MOV/CMP;
  - ALUControl, ResultSrc, ALUSrcB and ImmSrc encodings.
- Sub-module cond_unit: Zflag register (async reset, FlagWrite enable) plus the combinational CondEx evaluation.
- multicycle_ctrl_fsm holds the state register, next-state logic and output decode.

Test Plan:
- Release nRESET, then Instr = E0812003 (ADD R2, R1, R3):
  - reset cycle: all enables 0;
  - State sequence 0, 1, 6, 8, 0;
  - RegWrite = 1 only in state 8;
  - PCWrite = 1 only in state 0.
- Instr = E5912008 (LDR R2, [R1, #8]):
  - State sequence 0, 1, 2, 3, 4, 0;
  - state 2: ALUControl = 00, ImmSrc = 10;
  - state 3: AdrSrc = 1;
  - state 4: ResultSrc = 01.
- Instr = E3510005 (CMP R1, #5) with ALUZero = 1 in state 7, then Instr = 0A000002 (BEQ):
  - CMP: State sequence 0, 1, 7, 0 with FlagWrite = 1 in state 7;
  - BEQ: state 9 reached, PCWrite = 1, ImmSrc = 11.
- Repeat the previous scenario with ALUZero = 0, then Instr = 0A000002:
  - State sequence 0, 1, 0;
  - no PCWrite in DECODE;
  - total 2 cycles.
- Instr = E5812000 (STR):
  - State sequence 0, 1, 2, 5, 0;
  - state 5: MemWrite = 1, AdrSrc = 1, RegSrc = 10;
  - RegWrite = 0 throughout.
- Assert nRESET low during MEMRD:
  - State = 0 immediately, before the next edge;
  - Zflag = 0;
  - no RegWrite pulse afterwards.
